// File: rtl/cu_mul_pkg.sv
// Shared compute-unit package: multiplier opcodes, FSM encoding and saturation limits.
package cu_mul_pkg;

    localparam int unsigned CU_DATA_WIDTH   = 16;
    localparam int unsigned CU_SIGNAL_WIDTH = 3;
    localparam int unsigned CU_MR_WIDTH     = 2 * CU_DATA_WIDTH;

    localparam logic [CU_SIGNAL_WIDTH-1:0] MUL_OP_MULS  = 3'b000;
    localparam logic [CU_SIGNAL_WIDTH-1:0] MUL_OP_MULU  = 3'b001;
    localparam logic [CU_SIGNAL_WIDTH-1:0] MUL_OP_MACS  = 3'b010;
    localparam logic [CU_SIGNAL_WIDTH-1:0] MUL_OP_MSUBS = 3'b011;
    localparam logic [CU_SIGNAL_WIDTH-1:0] MUL_OP_CLRMR = 3'b100;

    // Two's complement extremes of the MR accumulator
    localparam logic [CU_MR_WIDTH-1:0] MUL_SAT_POS = {1'b0, {(CU_MR_WIDTH-1){1'b1}}};
    localparam logic [CU_MR_WIDTH-1:0] MUL_SAT_NEG = {1'b1, {(CU_MR_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_ACC  = 2'd2
    } mul_state_e;

endpackage

// File: rtl/cu_mul_core.sv
// Radix-2 shift-add iteration datapath: partial product, multiplicand/multiplier shifters, counter.
module cu_mul_core #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_i,
    input  logic                      step_i,
    input  logic [DATA_WIDTH-1:0]     mcand_i,
    input  logic [DATA_WIDTH-1:0]     mplier_i,
    output logic [2*DATA_WIDTH-1:0]   product_o,
    output logic                      last_c
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic [PW-1:0]         pp_q;
    logic [PW-1:0]         mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;
    logic [CW-1:0]         cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pp_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            pp_q     <= '0;
            mcand_q  <= PW'(mcand_i);
            mplier_q <= mplier_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                pp_q <= pp_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    assign product_o = pp_q;
    assign last_c    = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/cu_mul.sv
// Iterative multiply / multiply-accumulate unit with MR accumulator and sticky overflow flag.
// Define CU_MUL_SAT_EN to saturate MR on MACS/MSUBS overflow instead of wrapping.
module cu_mul
    import cu_mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = CU_DATA_WIDTH,
    parameter int unsigned SIGNAL_WIDTH = CU_SIGNAL_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ps_mul_en,
    input  logic [SIGNAL_WIDTH-1:0] ps_mul_op,
    input  logic [DATA_WIDTH-1:0]   xb_mul_dx,
    input  logic [DATA_WIDTH-1:0]   xb_mul_dy,
    output logic [DATA_WIDTH-1:0]   mul_xb_dl,
    output logic [DATA_WIDTH-1:0]   mul_xb_dh,
    output logic                    mul_ps_busy,
    output logic                    mul_ps_done,
    output logic                    mul_ps_mv
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    mul_state_e              state_q;
    logic [SIGNAL_WIDTH-1:0] op_q;
    logic                    sign_q;
    logic [PW-1:0]           mr_q, mr_d;
    logic                    mv_q, mv_d;
    logic                    busy_q, done_q;

    logic                    is_mul_c, op_signed_c, x_neg_c, y_neg_c, start_c, last_c;
    logic [DATA_WIDTH-1:0]   x_mag_c, y_mag_c;
    logic [PW-1:0]           product_c, prod_c, sum_c, diff_c;
    logic                    add_ovf_c, sub_ovf_c;

    // Start decode and operand sign/magnitude split; |0x8000| is exact as an unsigned value
    assign is_mul_c    = (ps_mul_op == SIGNAL_WIDTH'(MUL_OP_MULS))  || (ps_mul_op == SIGNAL_WIDTH'(MUL_OP_MULU)) ||
                         (ps_mul_op == SIGNAL_WIDTH'(MUL_OP_MACS))  || (ps_mul_op == SIGNAL_WIDTH'(MUL_OP_MSUBS));
    assign op_signed_c = (ps_mul_op != SIGNAL_WIDTH'(MUL_OP_MULU));
    assign x_neg_c     = op_signed_c & xb_mul_dx[DATA_WIDTH-1];
    assign y_neg_c     = op_signed_c & xb_mul_dy[DATA_WIDTH-1];
    assign x_mag_c     = x_neg_c ? DATA_WIDTH'(~xb_mul_dx + DATA_WIDTH'(1)) : xb_mul_dx;
    assign y_mag_c     = y_neg_c ? DATA_WIDTH'(~xb_mul_dy + DATA_WIDTH'(1)) : xb_mul_dy;
    assign start_c     = (state_q == ST_IDLE) && ps_mul_en;

    cu_mul_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .clk       (clk),
        .reset     (reset),
        .load_i    (start_c && is_mul_c),
        .step_i    (state_q == ST_CALC),
        .mcand_i   (x_mag_c),
        .mplier_i  (y_mag_c),
        .product_o (product_c),
        .last_c    (last_c)
    );

    assign prod_c    = sign_q ? PW'(~product_c + PW'(1)) : product_c;
    assign sum_c     = mr_q + prod_c;
    assign diff_c    = mr_q - prod_c;
    assign add_ovf_c = (mr_q[PW-1] == prod_c[PW-1]) && (sum_c[PW-1]  != mr_q[PW-1]);
    assign sub_ovf_c = (mr_q[PW-1] != prod_c[PW-1]) && (diff_c[PW-1] != mr_q[PW-1]);

    // Accumulator update applied in ACC
    always_comb begin
        mr_d = mr_q;
        mv_d = mv_q;
        case (op_q)
            SIGNAL_WIDTH'(MUL_OP_MULS),
            SIGNAL_WIDTH'(MUL_OP_MULU): mr_d = prod_c;
            SIGNAL_WIDTH'(MUL_OP_MACS): begin
                mr_d = sum_c;
                if (add_ovf_c) begin
                    mv_d = 1'b1;
`ifdef CU_MUL_SAT_EN
                    mr_d = mr_q[PW-1] ? PW'(MUL_SAT_NEG) : PW'(MUL_SAT_POS);
`endif
                end
            end
            SIGNAL_WIDTH'(MUL_OP_MSUBS): begin
                mr_d = diff_c;
                if (sub_ovf_c) begin
                    mv_d = 1'b1;
`ifdef CU_MUL_SAT_EN
                    mr_d = mr_q[PW-1] ? PW'(MUL_SAT_NEG) : PW'(MUL_SAT_POS);
`endif
                end
            end
            SIGNAL_WIDTH'(MUL_OP_CLRMR): begin
                mr_d = '0;
                mv_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Sequencing FSM with registered busy/done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            sign_q  <= 1'b0;
            mr_q    <= '0;
            mv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ps_mul_en) begin
                        op_q    <= ps_mul_op;
                        sign_q  <= x_neg_c ^ y_neg_c;
                        busy_q  <= 1'b1;
                        state_q <= is_mul_c ? ST_CALC : ST_ACC;
                    end
                end
                ST_CALC: begin
                    if (last_c) begin
                        state_q <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    mr_q    <= mr_d;
                    mv_q    <= mv_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mul_xb_dl   = mr_q[DATA_WIDTH-1:0];
    assign mul_xb_dh   = mr_q[PW-1:DATA_WIDTH];
    assign mul_ps_busy = busy_q;
    assign mul_ps_done = done_q;
    assign mul_ps_mv   = mv_q;

endmodule

// File: tb/tb_cu_mul.sv
// Directed bench for cu_mul: vector table of chained ops plus busy-ignore and mid-op reset sequences.
module tb_cu_mul;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps_mul_en;
    logic [2:0]  ps_mul_op;
    logic [15:0] xb_mul_dx, xb_mul_dy;
    logic [15:0] mul_xb_dl, mul_xb_dh;
    logic        mul_ps_busy, mul_ps_done, mul_ps_mv;

    int n_tests = 0;
    int n_fail  = 0;

    cu_mul dut (
        .clk         (clk),
        .reset       (reset),
        .ps_mul_en   (ps_mul_en),
        .ps_mul_op   (ps_mul_op),
        .xb_mul_dx   (xb_mul_dx),
        .xb_mul_dy   (xb_mul_dy),
        .mul_xb_dl   (mul_xb_dl),
        .mul_xb_dh   (mul_xb_dh),
        .mul_ps_busy (mul_ps_busy),
        .mul_ps_done (mul_ps_done),
        .mul_ps_mv   (mul_ps_mv)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] MULS = 3'b000, MULU = 3'b001, MACS = 3'b010,
                           MSUBS = 3'b011, CLRMR = 3'b100, UNDEF = 3'b111;

`ifdef CU_MUL_SAT_EN
    localparam logic [31:0] OVF_A = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_B = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_C = 32'h8000_0000;
`else
    localparam logic [31:0] OVF_A = 32'h8000_0000;
    localparam logic [31:0] OVF_B = 32'hBFFF_0000;
    localparam logic [31:0] OVF_C = 32'h4000_0000;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [15:0] dx;
        logic [15:0] dy;
        logic [31:0] mr;
        logic        mv;
        int          lat;
    } vec_t;

    vec_t tv[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op in the current cycle, wait for done, check latency and results
    task automatic run_op(input vec_t v, input string name);
        int lat;
        ps_mul_en = 1'b1;
        ps_mul_op = v.op;
        xb_mul_dx = v.dx;
        xb_mul_dy = v.dy;
        @(posedge clk); #1;
        ps_mul_en = 1'b0;
        xb_mul_dx = 16'($urandom);
        xb_mul_dy = 16'($urandom);
        lat = 0;
        while (!mul_ps_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(v.lat));
        chk({name, " mr"}, {mul_xb_dh, mul_xb_dl}, v.mr);
        chk({name, " mv"}, 32'(mul_ps_mv), 32'(v.mv));
        chk({name, " busy"}, 32'(mul_ps_busy), 32'd0);
    endtask

    initial begin
        int   lat;
        int   dones;
        vec_t v;

        tv[0]  = '{CLRMR, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0, 1};
        tv[1]  = '{MULS,  16'h0003, 16'hFFFC, 32'hFFFF_FFF4, 1'b0, 17};
        tv[2]  = '{MULU,  16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 17};
        tv[3]  = '{MULS,  16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 17};
        tv[4]  = '{MULS,  16'h0005, 16'h0007, 32'h0000_0023, 1'b0, 17};
        tv[5]  = '{MULS,  16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0, 17};
        tv[6]  = '{CLRMR, 16'h1234, 16'h5678, 32'h0000_0000, 1'b0, 1};
        tv[7]  = '{MACS,  16'h0002, 16'h0003, 32'h0000_0006, 1'b0, 17};
        tv[8]  = '{MSUBS, 16'h0001, 16'h0001, 32'h0000_0005, 1'b0, 17};
        tv[9]  = '{MACS,  16'hFFFE, 16'h0004, 32'hFFFF_FFFD, 1'b0, 17};
        tv[10] = '{UNDEF, 16'h0009, 16'h0009, 32'hFFFF_FFFD, 1'b0, 1};
        tv[11] = '{CLRMR, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0, 1};
        tv[12] = '{MACS,  16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 17};
        tv[13] = '{MACS,  16'h8000, 16'h8000, OVF_A,         1'b1, 17};
        tv[14] = '{MULU,  16'h0002, 16'h0003, 32'h0000_0006, 1'b1, 17};
        tv[15] = '{CLRMR, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0, 1};
        tv[16] = '{MACS,  16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 17};
        tv[17] = '{MSUBS, 16'h8000, 16'h7FFF, 32'h7FFF_8000, 1'b0, 17};
        tv[18] = '{MSUBS, 16'h8000, 16'h7FFF, OVF_B,         1'b1, 17};
        tv[19] = '{CLRMR, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0, 1};
        tv[20] = '{MSUBS, 16'h8000, 16'h8000, 32'hC000_0000, 1'b0, 17};
        tv[21] = '{MSUBS, 16'h8000, 16'h8000, 32'h8000_0000, 1'b0, 17};
        tv[22] = '{MSUBS, 16'h8000, 16'h8000, OVF_C,         1'b1, 17};
        tv[23] = '{CLRMR, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0, 1};

        reset     = 1'b1;
        ps_mul_en = 1'b0;
        ps_mul_op = 3'b000;
        xb_mul_dx = 16'h0;
        xb_mul_dy = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset mr", {mul_xb_dh, mul_xb_dl}, 32'h0);
        chk("reset busy/done/mv", {29'h0, mul_ps_busy, mul_ps_done, mul_ps_mv}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Chained table: each op starts in the done cycle of the previous one
        for (int i = 0; i < 24; i++) begin
            run_op(tv[i], $sformatf("vec%0d", i));
        end

        // Start strobes during busy must be ignored
        ps_mul_en = 1'b1;
        ps_mul_op = MULS;
        xb_mul_dx = 16'h0003;
        xb_mul_dy = 16'hFFFC;
        @(posedge clk); #1;
        ps_mul_en = 1'b0;
        lat = 0;
        while (!mul_ps_done && lat < 40) begin
            if (lat == 5 || lat == 10) begin
                ps_mul_en = 1'b1;
                ps_mul_op = MULU;
                xb_mul_dx = 16'hFFFF;
                xb_mul_dy = 16'hFFFF;
            end else begin
                ps_mul_en = 1'b0;
            end
            if (lat == 8) chk("ignore busy mid", 32'(mul_ps_busy), 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        ps_mul_en = 1'b0;
        chk("ignore latency", 32'(lat), 32'd17);
        chk("ignore mr", {mul_xb_dh, mul_xb_dl}, 32'hFFFF_FFF4);
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (mul_ps_done) dones++;
        end
        chk("ignore extra done", 32'(dones), 32'd0);
        chk("ignore mr hold", {mul_xb_dh, mul_xb_dl}, 32'hFFFF_FFF4);

        // Reset mid-MACS with nonzero MR and mv set
        run_op(tv[0], "rst clr");
        run_op(tv[12], "rst macs1");
        run_op(tv[13], "rst macs2");
        ps_mul_en = 1'b1;
        ps_mul_op = MACS;
        xb_mul_dx = 16'h0002;
        xb_mul_dy = 16'h0003;
        @(posedge clk); #1;
        ps_mul_en = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("midrst mr", {mul_xb_dh, mul_xb_dl}, 32'h0);
        chk("midrst busy/done/mv", {29'h0, mul_ps_busy, mul_ps_done, mul_ps_mv}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (mul_ps_done || mul_ps_busy) dones++;
        end
        chk("midrst no activity", 32'(dones), 32'd0);
        v = '{MULS, 16'h0002, 16'h0002, 32'h0000_0004, 1'b0, 17};
        run_op(v, "post rst muls");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
